// File: rtl/uart_rx_bridge.sv
// uart_rx_bridge
//   System-clock side of the UART receiver. Brings the receiver's byte-done
//   flag across from the baud domain, queues completed bytes in a FIFO and
//   exposes them to the CPU through a two-register MMIO window. Drives the
//   receiver's read enable and a level interrupt.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_rfin    receiver byte-done flag (baud domain), one rise per byte
//   rx_dout    receiver byte, stable while rx_rfin is high
//   rx_ce      receiver read enable (registered)
//   bus_ce     register access strobe, one cycle per access
//   bus_we     1 = write, 0 = read
//   bus_addr   0 = DATA, 1 = STAT (read) / CTRL (write)
//   bus_wdata  write data
//   bus_rdata  read data, valid the cycle after bus_ce
//   irq        level interrupt (registered)
//
// STAT layout: {16'b0, count[7:0], 3'b0, irq_en, rx_en, overrun, full, ~empty}
// CTRL layout: bit4 irq_en, bit3 rx_en, bit2 write-1-to-clear overrun
module uart_rx_bridge #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter bit RX_EN_RST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rfin,
    input  logic [7:0]  rx_dout,
    output logic        rx_ce,
    input  logic        bus_ce,
    input  logic        bus_we,
    input  logic        bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    // rx_rfin synchroniser stages: _p0 = s1, _p1 = s2, _p2 = s3
    logic rfin_p0;
    logic rfin_p1;
    logic rfin_p2;

    logic overrun;
    logic irq_en;
    logic rx_en;

    logic push;
    logic pop;
    logic accept;
    logic drop;
    logic full;
    logic empty;
    logic rd;
    logic ctrl_wr;
    logic [8:0]  count_ext;
    logic [31:0] stat_word;
    logic        unused_bits;

    function automatic logic [31:0] pack_stat(
        input logic [7:0] cnt,
        input logic       ie,
        input logic       re,
        input logic       ovr,
        input logic       fl,
        input logic       nempty
    );
        return {16'b0, cnt, 3'b0, ie, re, ovr, fl, nempty};
    endfunction

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push    = rfin_p1 & ~rfin_p2;
    assign rd      = bus_ce & ~bus_we;
    assign ctrl_wr = bus_ce & bus_we & bus_addr;
    assign pop     = rd & ~bus_addr & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign accept  = push & (~full | pop);
    assign drop    = push & full & ~pop;

    assign count_next = count + (AW+1)'(accept) - (AW+1)'(pop);

    assign count_ext = 9'(count);
    assign stat_word = pack_stat(count_ext[7:0], irq_en, rx_en, overrun, full, ~empty);

    assign unused_bits = ^{bus_wdata[31:5], bus_wdata[1:0], count_ext[8]};

    // Stage boundary: baud-domain flag into clk domain. Reset to 1 so a flag
    // already high at reset release is not seen as a new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rfin_p0 <= 1'b1;
            rfin_p1 <= 1'b1;
            rfin_p2 <= 1'b1;
        end else begin
            rfin_p0 <= rx_rfin;
            rfin_p1 <= rfin_p0;
            rfin_p2 <= rfin_p1;
        end
    end

    // Stage boundary: FIFO storage (data only, no reset). rx_dout has been
    // stable for at least two clocks by the time push fires.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wp] <= rx_dout;
        end
    end

    // Stage boundary: FIFO control, registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            irq_en    <= 1'b0;
            rx_en     <= RX_EN_RST;
            rx_ce     <= 1'b0;
            irq       <= 1'b0;
            bus_rdata <= '0;
        end else begin
            if (accept) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            count <= count_next;

            if (ctrl_wr) begin
                rx_en  <= bus_wdata[3];
                irq_en <= bus_wdata[4];
                if (bus_wdata[2]) begin
                    overrun <= 1'b0;
                end
            end
            // Placed after the clear so a drop in the same cycle wins.
            if (drop) begin
                overrun <= 1'b1;
            end

            // One slot of margin for the byte already in flight in the receiver.
            rx_ce <= rx_en & (count < DEPTH_M1);
            irq   <= irq_en & (count_next != '0);

            if (rd) begin
                if (bus_addr) begin
                    bus_rdata <= stat_word;
                end else if (pop) begin
                    bus_rdata <= {24'b0, mem[rp]};
                end else begin
                    bus_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_bridge.sv
// tb_uart_rx_bridge
//   Directed bench for uart_rx_bridge. A queue-based model tracks what the
//   FIFO must hold and what the registered outputs must show; a compare
//   process checks bus_rdata, rx_ce and irq against it on every falling edge.
//   Directed sequences add literal expectations that pin the model.
module tb_uart_rx_bridge;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        rx_rfin;
    logic [7:0]  rx_dout;
    logic        rx_ce;
    logic        bus_ce;
    logic        bus_we;
    logic        bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_rx_bridge #(
        .DEPTH     (DEPTH),
        .AW        (4),
        .RX_EN_RST (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_rfin   (rx_rfin),
        .rx_dout   (rx_dout),
        .rx_ce     (rx_ce),
        .bus_ce    (bus_ce),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  q[$];
    logic        m_live = 1'b0;
    logic        m_ovr, m_irq_en, m_rx_en;
    logic        m_rx_ce, m_irq;
    logic [31:0] m_rdata;
    logic [2:0]  hist;   // last three sampled rx_rfin values, [0] newest

    function automatic logic [31:0] model_stat(input int n, input logic ie,
                                               input logic re, input logic ovr);
        return {16'b0, 8'(n), 3'b0, ie, re, ovr, (n == DEPTH), (n != 0)};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_ovr    = 1'b0;
                m_irq_en = 1'b0;
                m_rx_en  = 1'b1;
                m_rx_ce  = 1'b0;
                m_irq    = 1'b0;
                m_rdata  = 32'h0;
                hist     = 3'b111;
                m_live   = 1'b1;
            end else if (m_live) begin
                automatic int   n     = q.size();
                automatic logic rise  = hist[1] & ~hist[2];
                automatic logic rdop  = bus_ce & ~bus_we;
                automatic logic wrc   = bus_ce & bus_we & bus_addr;
                automatic logic popm  = rdop & ~bus_addr & (n > 0);
                automatic logic [7:0] dummy;
                if (rdop) begin
                    if (bus_addr) m_rdata = model_stat(n, m_irq_en, m_rx_en, m_ovr);
                    else if (popm) m_rdata = {24'b0, q[0]};
                    else m_rdata = 32'h0;
                end
                m_rx_ce = m_rx_en && (n < DEPTH - 1);
                if (popm) dummy = q.pop_front();
                if (wrc && bus_wdata[2]) m_ovr = 1'b0;
                if (rise) begin
                    if (n < DEPTH || popm) q.push_back(rx_dout);
                    else m_ovr = 1'b1;
                end
                m_irq = m_irq_en && (q.size() != 0);
                if (wrc) begin
                    m_rx_en  = bus_wdata[3];
                    m_irq_en = bus_wdata[4];
                end
                hist = {hist[1:0], rx_rfin};
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("cyc_rdata", bus_rdata, m_rdata);
                check("cyc_rx_ce", 32'(rx_ce), 32'(m_rx_ce));
                check("cyc_irq",   32'(irq),   32'(m_irq));
            end
        end
    end

    // ---------------- driver helpers (called at a falling edge) ----------------
    task automatic bus_read(input logic addr, output logic [31:0] d);
        bus_ce = 1'b1; bus_we = 1'b0; bus_addr = addr;
        @(negedge clk);
        d = bus_rdata;
        bus_ce = 1'b0;
    endtask

    task automatic bus_write(input logic addr, input logic [31:0] w);
        bus_ce = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = w;
        @(negedge clk);
        bus_ce = 1'b0; bus_we = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_dout = b; rx_rfin = 1'b1;
        repeat (3) @(negedge clk);
        rx_rfin = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        rst = 1'b1; rx_rfin = 1'b0; rx_dout = 8'h00;
        bus_ce = 1'b0; bus_we = 1'b0; bus_addr = 1'b0; bus_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_irq",   32'(irq),   32'h0);
        check("rst_rx_ce", 32'(rx_ce), 32'h0);
        @(negedge clk);
        check("rx_ce_after_rst", 32'(rx_ce), 32'h1);

        // single byte, 3-clock latency
        rx_dout = 8'h5A; rx_rfin = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(1'b1, d);
        check("stat_one_byte", d, 32'h0000_0109);
        rx_rfin = 1'b0;
        bus_read(1'b0, d);
        check("data_5a", d, 32'h0000_005A);
        bus_read(1'b1, d);
        check("stat_empty", d, 32'h0000_0008);
        bus_read(1'b0, d);
        check("data_empty", d, 32'h0);
        bus_write(1'b0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("rdata_hold", bus_rdata, 32'h0);

        // fill to full, overrun, clear, drain
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("rx_ce_full", 32'(rx_ce), 32'h0);
        bus_read(1'b1, d);
        check("stat_full", d, 32'h0000_100B);
        push_byte(8'hEE);
        bus_read(1'b1, d);
        check("stat_overrun", d, 32'h0000_100F);
        bus_write(1'b1, 32'h0000_000C);
        bus_read(1'b1, d);
        check("stat_ovr_clr", d, 32'h0000_100B);
        for (int i = 0; i < 16; i++) begin
            bus_read(1'b0, d);
            check("drain1", d, 32'(i));
        end
        bus_read(1'b1, d);
        check("stat_drained", d, 32'h0000_0008);

        // full FIFO: push and pop in the same cycle
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        rx_dout = 8'hAB; rx_rfin = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(1'b0, d);
        check("simul_oldest", d, 32'h0000_0010);
        rx_rfin = 1'b0;
        @(negedge clk);
        bus_read(1'b1, d);
        check("stat_simul", d, 32'h0000_100B);
        for (int i = 1; i < 16; i++) begin
            bus_read(1'b0, d);
            check("drain2", d, 32'(8'h10 + i));
        end
        bus_read(1'b0, d);
        check("drain2_ab", d, 32'h0000_00AB);

        // rx_rfin held high across reset
        rx_dout = 8'h77; rx_rfin = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        bus_read(1'b1, d);
        check("stat_after_rst", d, 32'h0000_0008);
        bus_read(1'b0, d);
        check("data_after_rst", d, 32'h0);
        rx_rfin = 1'b0;
        @(negedge clk);
        push_byte(8'h33);
        bus_read(1'b1, d);
        check("stat_repush", d, 32'h0000_0109);
        bus_read(1'b0, d);
        check("data_33", d, 32'h0000_0033);

        // interrupt
        bus_write(1'b1, 32'h0000_0018);
        push_byte(8'h41);
        check("irq_set", 32'(irq), 32'h1);
        bus_read(1'b0, d);
        check("data_41", d, 32'h0000_0041);
        check("irq_clr", 32'(irq), 32'h0);
        bus_write(1'b1, 32'h0000_0008);
        push_byte(8'h42);
        check("irq_disabled", 32'(irq), 32'h0);
        bus_read(1'b1, d);
        check("stat_irq_off", d, 32'h0000_0109);
        bus_read(1'b0, d);
        check("data_42", d, 32'h0000_0042);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
